ibex_lsu_ctrl: RTL

IBEX_LSU_CTRL -- requirements
Module: ibex_lsu_ctrl

---
 rtl/ibex_pkg.sv | 47 ++++
 rtl/ibex_lsu_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ibex_pkg.sv
// Shared types and helpers for the Ibex load/store unit controller.
// Access-type encoding, FSM states, and byte-lane helpers used by ibex_lsu_ctrl.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10,
    LSU_RSVD = 2'b11
  } lsu_type_e;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    WAIT_GNT        = 3'd1,
    WAIT_RVALID     = 3'd2,
    WAIT_GNT_MIS    = 3'd3,
    WAIT_RVALID_MIS = 3'd4
  } lsu_state_e;

  // The reserved type encoding behaves exactly like a word access.
  function automatic logic is_misaligned(lsu_type_e t, logic [1:0] off);
    case (t)
      LSU_HALF: is_misaligned = (off == 2'd3);
      LSU_BYTE: is_misaligned = 1'b0;
      default:  is_misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(lsu_type_e t, logic [1:0] off, logic second);
    case (t)
      LSU_HALF: begin
        if (off == 2'd3) byte_enable = second ? 4'b0001 : 4'b1000;
        else             byte_enable = 4'b0011 << off;
      end
      LSU_BYTE: byte_enable = 4'b0001 << off;
      default:  byte_enable = second ? (4'b1111 >> (3'd4 - {1'b0, off}))
                                     : (4'b1111 << off);
    endcase
  endfunction

  function automatic logic [31:0] rotl_bytes(logic [31:0] d, logic [1:0] off);
    logic [63:0] t;
    t = {d, d} << {off, 3'b000};
    return t[63:32];
  endfunction

endpackage

// File: rtl/ibex_lsu_ctrl.sv
// Load/store unit controller: drives the data bus, splits or rejects misaligned
// accesses, and aligns and extends load data for writeback.
module ibex_lsu_ctrl
  import ibex_pkg::*;
#(
  parameter bit MisalignedSplit = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_first_q;
  lsu_type_e   type_q;
  logic        we_q;
  logic        sign_ext_q;
  logic        split_q;
  logic        err_q;
  logic        mis_err_q;

  logic        idle;
  logic        second_part;
  logic        req_mis;
  lsu_type_e   req_type;
  lsu_type_e   cur_type;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_off;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] rdata_cat;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_ext;

  assign idle        = (state_q == IDLE);
  assign second_part = (state_q == WAIT_GNT_MIS) || (state_q == WAIT_RVALID_MIS);
  assign req_type    = lsu_type_e'(lsu_type_i);
  assign req_mis     = is_misaligned(req_type, adder_result_ex_i[1:0]);

  // In IDLE the request is served straight from the ID/EX inputs; afterwards
  // everything comes from the captured copy so the bus sees stable values.
  always_comb begin
    cur_addr  = idle ? adder_result_ex_i : addr_q;
    cur_type  = idle ? req_type          : type_q;
    cur_wdata = idle ? lsu_wdata_i       : wdata_q;
    cur_off   = cur_addr[1:0];
  end

  assign data_req_o   = (idle && lsu_req_i && !(req_mis && !MisalignedSplit)) ||
                        (state_q == WAIT_GNT) || (state_q == WAIT_GNT_MIS);
  assign data_addr_o  = second_part ? {addr_q[31:2] + 30'd1, 2'b00} : {cur_addr[31:2], 2'b00};
  assign data_we_o    = idle ? lsu_we_i : we_q;
  assign data_be_o    = byte_enable(cur_type, cur_off, second_part);
  assign data_wdata_o = rotl_bytes(cur_wdata, cur_off);

  // mis_err_q marks a rejected misaligned access: complete with an error, no bus traffic.
  assign resp_valid = ((state_q == WAIT_RVALID) && (mis_err_q || (data_rvalid_i && !split_q))) ||
                      ((state_q == WAIT_RVALID_MIS) && data_rvalid_i);
  assign resp_err   = mis_err_q || err_q || data_err_i;

  assign lsu_resp_valid_o = resp_valid;
  assign load_err_o       = resp_valid && resp_err && !we_q;
  assign store_err_o      = resp_valid && resp_err && we_q;
  assign busy_o           = !idle;

  always_comb begin
    rdata_cat   = second_part ? {data_rdata_i, rdata_first_q} : {32'h0, data_rdata_i};
    rdata_shift = 32'(rdata_cat >> {addr_q[1:0], 3'b000});
    case (type_q)
      LSU_BYTE: rdata_ext = sign_ext_q ? {{24{rdata_shift[7]}}, rdata_shift[7:0]}
                                       : {24'h0, rdata_shift[7:0]};
      LSU_HALF: rdata_ext = sign_ext_q ? {{16{rdata_shift[15]}}, rdata_shift[15:0]}
                                       : {16'h0, rdata_shift[15:0]};
      default:  rdata_ext = rdata_shift;
    endcase
  end

  assign lsu_rdata_o = resp_valid ? rdata_ext : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      rdata_first_q <= 32'h0;
      type_q        <= LSU_WORD;
      we_q          <= 1'b0;
      sign_ext_q    <= 1'b0;
      split_q       <= 1'b0;
      err_q         <= 1'b0;
      mis_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q     <= adder_result_ex_i;
            wdata_q    <= lsu_wdata_i;
            type_q     <= req_type;
            we_q       <= lsu_we_i;
            sign_ext_q <= lsu_sign_ext_i;
            split_q    <= req_mis && MisalignedSplit;
            err_q      <= 1'b0;
            if (req_mis && !MisalignedSplit) begin
              mis_err_q <= 1'b1;
              state_q   <= WAIT_RVALID;
            end else begin
              state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) state_q <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (mis_err_q) begin
            mis_err_q <= 1'b0;
            state_q   <= IDLE;
          end else if (data_rvalid_i) begin
            if (split_q) begin
              rdata_first_q <= data_rdata_i;
              err_q         <= data_err_i;
              state_q       <= WAIT_GNT_MIS;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_GNT_MIS: begin
          if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
        end
        WAIT_RVALID_MIS: begin
          if (data_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
